// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin frame collector: slot indices,
// frame geometry and the assembly FSM state encoding.
package rr_pkg;

  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;

  localparam int NUM_SLOTS = 4;
  localparam int FRAME_W   = 4;

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } collector_state_t;

endpackage

// File: rtl/rr_frame_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is presented
// combinationally whenever the FIFO is non-empty. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module rr_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign pop_en    = pop && !empty;
  assign push_en   = push && (!full || pop_en);
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only observable through the level-gated head.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rr_frame_collector.sv
// Rebuilds 4-bit frames from the round-robin arbiter's serial output,
// buffers completed frames in a FWFT FIFO and flags slot-sequence breaks
// and dropped frames.
module rr_frame_collector
  import rr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [1:0]                    in_slot,
  input  logic                          in_bit,
  output logic [FRAME_W-1:0]            frame_data,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          resync,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt
);

  collector_state_t   state, state_n;
  logic [1:0]         expected, expected_n;
  logic [FRAME_W-1:0] partial, partial_n;
  logic               resync_n;
  logic               push;
  logic [FRAME_W-1:0] push_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop_fire;
  logic               drop;

  assign frame_valid = !fifo_empty;
  assign pop_fire    = frame_valid && frame_ready;
  assign drop        = push && fifo_full && !pop_fire;

  rr_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FRAME_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_fire),
    .head_data (frame_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Assembly FSM next-state: collect bits in slot order, push on slot D,
  // and recover from slot-sequence breaks.
  always_comb begin
    state_n    = state;
    expected_n = expected;
    partial_n  = partial;
    resync_n   = 1'b0;
    push       = 1'b0;
    push_data  = {in_bit, partial[2:0]};
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_slot == SLOT_A) begin
            partial_n  = {3'b000, in_bit};
            expected_n = SLOT_B;
            state_n    = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (in_slot == expected) begin
            if (in_slot == SLOT_D) begin
              push       = 1'b1;
              partial_n  = '0;
              expected_n = SLOT_A;
            end else begin
              partial_n[in_slot] = in_bit;
              expected_n         = expected + 2'd1;
            end
          end else begin
            resync_n = 1'b1;
            if (in_slot == SLOT_A) begin
              partial_n  = {3'b000, in_bit};
              expected_n = SLOT_B;
            end else begin
              partial_n  = '0;
              expected_n = SLOT_A;
              state_n    = HUNT;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // FSM state, partial frame and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HUNT;
      expected <= SLOT_A;
      partial  <= '0;
      resync   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      expected <= expected_n;
      partial  <= partial_n;
      resync   <= resync_n;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_frame_collector.sv
// Directed testbench for rr_frame_collector with hand-computed expectations.
module tb_rr_frame_collector;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_slot;
  logic       in_bit;
  logic [3:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic [2:0] fifo_level;
  logic       resync;
  logic       overflow;
  logic [7:0] drop_cnt;

  int checkCount;
  int passCount;

  rr_frame_collector #(
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_slot     (in_slot),
    .in_bit      (in_bit),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .fifo_level  (fifo_level),
    .resync      (resync),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock cycle of stimulus; inputs change on the falling edge and the
  // outputs are left settled 1 ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic b, input logic r);
    @(negedge clk);
    in_valid    = v;
    in_slot     = s;
    in_bit      = b;
    frame_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(1'b0, 2'd0, 1'b0, r);
  endtask

  // Full frame in slot order; frame_ready is raised only on the slot-D cycle.
  task automatic sendFrame(input logic [3:0] d, input logic readyLast);
    logic [3:0] v;
    v = d;
    applyStimulus(1'b1, 2'd0, v[0], 1'b0);
    applyStimulus(1'b1, 2'd1, v[1], 1'b0);
    applyStimulus(1'b1, 2'd2, v[2], 1'b0);
    applyStimulus(1'b1, 2'd3, v[3], readyLast);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_slot     = 2'd0;
    in_bit      = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] expData [4];
    checkCount  = 0;
    passCount   = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    in_slot     = 2'd0;
    in_bit      = 1'b0;
    frame_ready = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_valid", int'(frame_valid), 0);
    checkOutput("reset_level", int'(fifo_level), 0);
    checkOutput("reset_data", int'(frame_data), 0);
    checkOutput("reset_resync", int'(resync), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_dropcnt", int'(drop_cnt), 0);

    // Test 1: basic frame
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    checkOutput("t1_not_yet_valid", int'(frame_valid), 0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    checkOutput("t1_valid", int'(frame_valid), 1);
    checkOutput("t1_data", int'(frame_data), 13);
    checkOutput("t1_level", int'(fifo_level), 1);
    checkOutput("t1_resync", int'(resync), 0);
    idleCycle(1'b1);
    checkOutput("t1_pop_level", int'(fifo_level), 0);
    checkOutput("t1_pop_valid", int'(frame_valid), 0);

    // Test 2: HUNT ignores non-zero slots after a fresh reset
    doReset();
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    checkOutput("t2_hunt_resync_c", int'(resync), 0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    checkOutput("t2_hunt_level", int'(fifo_level), 0);
    checkOutput("t2_hunt_resync_d", int'(resync), 0);
    sendFrame(4'b1111, 1'b0);
    checkOutput("t2_level", int'(fifo_level), 1);
    checkOutput("t2_data", int'(frame_data), 15);
    checkOutput("t2_resync", int'(resync), 0);
    idleCycle(1'b1);
    checkOutput("t2_drained", int'(fifo_level), 0);

    // Test 3: sequence break 0,1,3 then a good frame with bit3=1
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    checkOutput("t3_resync_before", int'(resync), 0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("t3_resync_pulse", int'(resync), 1);
    checkOutput("t3_no_frame", int'(fifo_level), 0);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("t3_resync_after", int'(resync), 0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    checkOutput("t3_data", int'(frame_data), 8);
    checkOutput("t3_level", int'(fifo_level), 1);
    checkOutput("t3_resync_end", int'(resync), 0);

    // Test 3b: break on slot 0 restarts a frame immediately
    doReset();
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    checkOutput("t3b_resync", int'(resync), 1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("t3b_data", int'(frame_data), 5);
    checkOutput("t3b_level", int'(fifo_level), 1);

    // Test 4: overflow with FIFO_DEPTH=4
    doReset();
    for (int i = 1; i <= 4; i++) begin
      sendFrame(4'(i), 1'b0);
    end
    checkOutput("t4_full_level", int'(fifo_level), 4);
    checkOutput("t4_no_overflow_yet", int'(overflow), 0);
    sendFrame(4'd5, 1'b0);
    checkOutput("t4_level", int'(fifo_level), 4);
    checkOutput("t4_overflow", int'(overflow), 1);
    checkOutput("t4_dropcnt", int'(drop_cnt), 1);
    checkOutput("t4_head", int'(frame_data), 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t4_pop_order_%0d", i), int'(frame_data), i);
      idleCycle(1'b1);
    end
    checkOutput("t4_drained_level", int'(fifo_level), 0);
    checkOutput("t4_drained_valid", int'(frame_valid), 0);
    checkOutput("t4_overflow_sticky", int'(overflow), 1);
    idleCycle(1'b1);
    checkOutput("t4_pop_empty_level", int'(fifo_level), 0);

    // Test 5: full FIFO, push and pop in the same cycle
    doReset();
    expData[0] = 4'b0111;
    expData[1] = 4'b1000;
    expData[2] = 4'b1001;
    expData[3] = 4'b1010;
    sendFrame(4'b0110, 1'b0);
    sendFrame(4'b0111, 1'b0);
    sendFrame(4'b1000, 1'b0);
    sendFrame(4'b1001, 1'b0);
    checkOutput("t5_full", int'(fifo_level), 4);
    sendFrame(4'b1010, 1'b1);
    checkOutput("t5_level", int'(fifo_level), 4);
    checkOutput("t5_overflow", int'(overflow), 0);
    checkOutput("t5_dropcnt", int'(drop_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t5_order_%0d", i), int'(frame_data), int'(expData[i]));
      idleCycle(1'b1);
    end
    checkOutput("t5_drained", int'(fifo_level), 0);

    // Test 5b: one entry held, push and pop together keep level at 1
    sendFrame(4'b0011, 1'b0);
    sendFrame(4'b1100, 1'b1);
    checkOutput("t5b_level", int'(fifo_level), 1);
    checkOutput("t5b_data", int'(frame_data), 12);

    // Test 6: asynchronous reset mid-frame with a frame buffered
    doReset();
    sendFrame(4'b0101, 1'b0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
    checkOutput("t6_pre_level", int'(fifo_level), 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t6_async_valid", int'(frame_valid), 0);
    checkOutput("t6_async_level", int'(fifo_level), 0);
    checkOutput("t6_async_data", int'(frame_data), 0);
    checkOutput("t6_async_resync", int'(resync), 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    idleCycle(1'b0);
    checkOutput("t6_after_level", int'(fifo_level), 0);
    checkOutput("t6_after_valid", int'(frame_valid), 0);
    checkOutput("t6_after_resync", int'(resync), 0);

    // Test 7: drop counter saturates at all-ones
    doReset();
    for (int i = 0; i < 4 + 260; i++) begin
      sendFrame(4'b1110, 1'b0);
    end
    checkOutput("t7_dropcnt_sat", int'(drop_cnt), 255);
    checkOutput("t7_overflow", int'(overflow), 1);
    checkOutput("t7_level", int'(fifo_level), 4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
